// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb_pkg
//  Purpose  : Shared controller command codes and arbiter FSM state encoding
//             for the SDRAM port arbiter.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sdram_arb_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR256 = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb_pick
//  Purpose  : Combinational winner selection. Priority order:
//             starved round-robin channel (lowest index), then ch0 (realtime),
//             then the first requester in 1..NCH-1 at/after rr_ptr, wrapping.
//  Ports    : req_i     per-channel request level
//             full_i    per-channel "starve count saturated" flag
//             rr_ptr_i  round-robin start point (1..NCH-1)
//             sel_o     winning channel index
//             any_o     at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module sdram_arb_pick #(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [NCH-1:0] full_i,
    input  logic [IDW-1:0] rr_ptr_i,
    output logic [IDW-1:0] sel_o,
    output logic           any_o
);

    logic w_found;
    int   w_idx;

    assign any_o = |req_i;

    always_comb begin
        sel_o   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        // Descending scan so the lowest starved index is the one left standing.
        for (int i = NCH - 1; i >= 1; i--) begin
            if (req_i[i] && full_i[i]) begin
                sel_o   = IDW'(i);
                w_found = 1'b1;
            end
        end
        if (!w_found && req_i[0]) begin
            sel_o   = '0;
            w_found = 1'b1;
        end
        // Descending offset so the requester closest to rr_ptr wins.
        if (!w_found) begin
            for (int k = NCH - 2; k >= 0; k--) begin
                w_idx = ((int'(rr_ptr_i) - 1 + k) % (NCH - 1)) + 1;
                if (req_i[w_idx]) begin
                    sel_o = IDW'(w_idx);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_port_arbiter
//  Purpose  : N-channel command arbiter in front of the SDRAM controller.
//             Latches the winning command, holds it until acknowledged,
//             tracks the owner and steers data-valid strobes to it.
//  Ports    : clk_i               SDRAM-domain clock
//             rst_i               synchronous reset, active low
//             req_i/cmd_i/addr_i  per-channel request, command, word address
//             gnt_o               one-cycle accept pulse per channel
//             rd_valid_o/wr_valid_o  controller strobes steered to owner
//             owner_o, busy_o, err_o  status (err is sticky)
//             sys_CMD_o/sys_ADDR_o    command toward controller
//             sys_cmd_ack_i, sys_rd_data_valid_i, sys_wr_data_valid_i
//  Revision : 1.0  initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int AW     = 23,
    parameter int STARVE = 64,
    parameter int IDW    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    req_i,
    input  logic [2*NCH-1:0]  cmd_i,
    input  logic [AW*NCH-1:0] addr_i,
    output logic [NCH-1:0]    gnt_o,
    output logic [NCH-1:0]    rd_valid_o,
    output logic [NCH-1:0]    wr_valid_o,
    output logic [IDW-1:0]    owner_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [1:0]        sys_CMD_o,
    output logic [AW-1:0]     sys_ADDR_o,
    input  logic [1:0]        sys_cmd_ack_i,
    input  logic              sys_rd_data_valid_i,
    input  logic              sys_wr_data_valid_i
);

    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE);

    arb_state_e     state_q,  state_d;
    logic [IDW-1:0] sel_q,    sel_d;
    logic [1:0]     cmd_q,    cmd_d;
    logic [AW-1:0]  addr_q,   addr_d;
    logic [NCH-1:0] gnt_q,    gnt_d;
    logic [IDW-1:0] owner_q,  owner_d;
    logic           busy_q,   busy_d;
    logic           err_q,    err_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     starve_q [NCH];
    logic [7:0]     starve_d [NCH];

    logic [NCH-1:0] w_full;
    logic [IDW-1:0] w_sel;
    logic           w_any;
    logic [NCH-1:0] w_owner_dec;

    // ch0 is realtime and never takes part in starvation promotion.
    assign w_full[0] = 1'b0;
    for (genvar g = 1; g < NCH; g++) begin : g_full
        assign w_full[g] = (starve_q[g] == c_STARVE_MAX);
    end

    sdram_arb_pick #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_pick (
        .req_i    (req_i),
        .full_i   (w_full),
        .rr_ptr_i (rr_ptr_q),
        .sel_o    (w_sel),
        .any_o    (w_any)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cmd_q    <= CMD_NOP;
            addr_q   <= '0;
            gnt_q    <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            rr_ptr_q <= IDW'(1);
            for (int i = 0; i < NCH; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            rr_ptr_q <= rr_ptr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        gnt_d    = '0;
        owner_d  = owner_q;
        err_d    = err_q;
        rr_ptr_d = rr_ptr_q;
        starve_d = starve_q;

        for (int i = 0; i < NCH; i++) begin
            if (req_i[i] && (cmd_i[2*i +: 2] == CMD_NOP)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    sel_d   = w_sel;
                    cmd_d   = cmd_i[2*int'(w_sel) +: 2];
                    addr_d  = addr_i[AW*int'(w_sel) +: AW];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Command is frozen here; only the ack can move us on.
                if (sys_cmd_ack_i != CMD_NOP) begin
                    cmd_d        = CMD_NOP;
                    owner_d      = sel_q;
                    gnt_d[sel_q] = 1'b1;
                    state_d      = S_BUSY;
                    if (sys_cmd_ack_i != cmd_q) begin
                        err_d = 1'b1;
                    end
                    if (sel_q != '0) begin
                        rr_ptr_d = (sel_q == IDW'(NCH - 1)) ? IDW'(1) : sel_q + IDW'(1);
                    end
                    for (int i = 1; i < NCH; i++) begin
                        if (IDW'(i) == sel_q) begin
                            starve_d[i] = '0;
                        end else if (req_i[i] && (starve_q[i] != c_STARVE_MAX)) begin
                            starve_d[i] = starve_q[i] + 8'd1;
                        end
                    end
                end
            end
            S_BUSY: begin
                if (sys_cmd_ack_i == CMD_NOP) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        starve_d[0] = '0;
        for (int i = 1; i < NCH; i++) begin
            if (!req_i[i]) begin
                starve_d[i] = '0;
            end
        end
    end

    assign busy_d = (state_d != S_IDLE);

    // Strobes only reach a channel while its command is actually executing.
    assign w_owner_dec = (state_q == S_BUSY) ? ({{(NCH-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign rd_valid_o  = w_owner_dec & {NCH{sys_rd_data_valid_i}};
    assign wr_valid_o  = w_owner_dec & {NCH{sys_wr_data_valid_i}};

    assign gnt_o      = gnt_q;
    assign owner_o    = owner_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
    assign sys_CMD_o  = cmd_q;
    assign sys_ADDR_o = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_port_arbiter
//  Purpose  : Self-checking bench for sdram_port_arbiter with a behavioural
//             priority/starvation model and a simple controller responder.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int NCH = 4, AW = 23, STARVE = 4, IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [2*NCH-1:0]  cmd = '0;
    logic [AW*NCH-1:0] addr = '0;
    logic [NCH-1:0]    gnt, rd_valid, wr_valid;
    logic [IDW-1:0]    owner;
    logic              busy, err;
    logic [1:0]        sys_CMD;
    logic [AW-1:0]     sys_ADDR;
    logic [1:0]        ack = 2'b00;
    logic              rdv = 1'b0, wrv = 1'b0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NCH(NCH), .AW(AW), .STARVE(STARVE), .IDW(IDW)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .cmd_i(cmd), .addr_i(addr),
        .gnt_o(gnt), .rd_valid_o(rd_valid), .wr_valid_o(wr_valid), .owner_o(owner),
        .busy_o(busy), .err_o(err), .sys_CMD_o(sys_CMD), .sys_ADDR_o(sys_ADDR),
        .sys_cmd_ack_i(ack), .sys_rd_data_valid_i(rdv), .sys_wr_data_valid_i(wrv)
    );

    int n_checks = 0, n_fail = 0;

    // Behavioural model: starvation counts, round-robin start, sticky error.
    int m_starve[NCH];
    int m_rr;
    bit m_err;

    // Results of the most recent serve() call.
    logic [1:0]    s_cmd, s_cmd_ack;
    logic [AW-1:0] s_addr, s_addr_ack;
    int            s_gch, s_exp, s_good, s_bad, s_glat;
    bit            s_to;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) m_starve[i] = 0;
        m_rr = 1;
        m_err = 1'b0;
    endfunction

    function automatic int model_pick(input logic [NCH-1:0] r);
        int c;
        for (int i = 1; i < NCH; i++) if (r[i] && m_starve[i] == STARVE) return i;
        if (r[0]) return 0;
        for (int k = 0; k < NCH - 1; k++) begin
            c = (m_rr - 1 + k) % (NCH - 1) + 1;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_grant(input int w, input logic [NCH-1:0] r);
        for (int i = 1; i < NCH; i++) begin
            if (i == w) m_starve[i] = 0;
            else if (!r[i]) m_starve[i] = 0;
            else if (m_starve[i] < STARVE) m_starve[i] = m_starve[i] + 1;
        end
        if (w != 0) m_rr = (w == NCH - 1) ? 1 : w + 1;
    endfunction

    function automatic int onehot_idx(input logic [NCH-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Controller responder: waits for a command, acks after lat cycles,
    // holds the ack for hold cycles with nstb strobes, then goes idle.
    task automatic serve(input int lat, input logic [1:0] ack_code, input int hold, input int nstb,
                         input bit use_rd, input logic [NCH-1:0] raise, input bit keep);
        int n;
        logic [NCH-1:0] rsnap, exp_v;
        s_to = 1'b0; s_gch = -1; s_good = 0; s_bad = 0; s_glat = 0; n = 0;
        while (sys_CMD === CMD_NOP && n < 50) begin @(negedge clk); n++; end
        if (sys_CMD === CMD_NOP) begin s_to = 1'b1; return; end
        s_exp = model_pick(req);
        s_cmd = sys_CMD; s_addr = sys_ADDR;
        req = req | raise;
        repeat (lat) @(negedge clk);
        s_cmd_ack = sys_CMD; s_addr_ack = sys_ADDR;
        ack = (ack_code == CMD_NOP) ? s_cmd : ack_code;
        rsnap = req;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt === '0 && n < 10);
        s_glat = n;
        if (gnt === '0) begin s_to = 1'b1; ack = CMD_NOP; return; end
        s_gch = onehot_idx(gnt);
        model_grant(s_exp, rsnap);
        if (ack !== s_cmd) m_err = 1'b1;
        exp_v = '0;
        if (s_exp >= 0) exp_v[s_exp] = 1'b1;
        for (int h = 0; h < hold; h++) begin
            rdv = use_rd && (h < nstb);
            wrv = !use_rd && (h < nstb);
            #1;
            if (rd_valid === (rdv ? exp_v : '0) && wr_valid === (wrv ? exp_v : '0) &&
                owner === IDW'(s_exp) && busy === 1'b1 && (h == 0 || gnt === '0)) s_good++;
            else s_bad++;
            @(negedge clk);
        end
        rdv = 1'b0; wrv = 1'b0; ack = CMD_NOP;
        if (!keep && s_gch >= 0) req[s_gch] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drop_all();
        req = '0;
        for (int i = 0; i < NCH; i++) m_starve[i] = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdv = 1'b1; wrv = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (sys_CMD !== 2'b00) begin n_fail++; $display("FAIL reset_cmd got=%b exp=00", sys_CMD); end
        n_checks++; if (sys_ADDR !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", sys_ADDR); end
        n_checks++; if (gnt !== '0 || owner !== '0) begin n_fail++; $display("FAIL reset_gnt_owner got=%b/%0d exp=0000/0", gnt, owner); end
        n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err got=%b/%b exp=0/0", busy, err); end
        n_checks++; if (rd_valid !== '0 || wr_valid !== '0) begin n_fail++; $display("FAIL reset_strobes got=%b/%b exp=0000/0000", rd_valid, wr_valid); end
        rdv = 1'b0; wrv = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_read();
        cmd[1:0] = CMD_RD32; addr[AW-1:0] = 23'h37FC0; req = 4'b0001;
        @(negedge clk);
        n_checks++; if (sys_CMD !== CMD_RD32 || sys_ADDR !== 23'h37FC0) begin n_fail++; $display("FAIL single_issue got=%b/%h exp=10/37fc0", sys_CMD, sys_ADDR); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        serve(2, CMD_NOP, 4, 4, 1'b1, '0, 1'b0);
        n_checks++; if (s_to !== 1'b0 || s_gch !== 0) begin n_fail++; $display("FAIL single_gnt got=%0d to=%0d exp=0", s_gch, s_to); end
        n_checks++; if (s_glat !== 1) begin n_fail++; $display("FAIL single_gnt_latency got=%0d exp=1", s_glat); end
        n_checks++; if (s_good !== 4 || s_bad !== 0) begin n_fail++; $display("FAIL single_rd_valid good=%0d bad=%0d exp=4/0", s_good, s_bad); end
    endtask

    task automatic test_round_robin();
        int order[6] = '{1, 2, 3, 1, 2, 3};
        for (int i = 1; i < NCH; i++) begin cmd[2*i +: 2] = CMD_RD32; addr[AW*i +: AW] = AW'(32'h100 * i); end
        req = 4'b1110;
        for (int j = 0; j < 6; j++) begin
            serve(1, CMD_NOP, 6, 4, 1'b1, '0, 1'b1);
            n_checks++; if (s_gch !== order[j] || s_exp !== order[j]) begin n_fail++; $display("FAIL rr_order[%0d] got=%0d model=%0d exp=%0d", j, s_gch, s_exp, order[j]); end
            n_checks++; if (s_bad !== 0) begin n_fail++; $display("FAIL rr_steering[%0d] bad=%0d exp=0", j, s_bad); end
        end
        drop_all();
    endtask

    task automatic test_starvation();
        int order[6] = '{0, 0, 0, 0, 1, 0};
        cmd[1:0] = CMD_RD32; cmd[3:2] = CMD_RD32;
        req = 4'b0011;
        for (int j = 0; j < 6; j++) begin
            serve(1, CMD_NOP, 2, 1, 1'b1, '0, 1'b1);
            n_checks++; if (s_gch !== order[j] || s_exp !== order[j]) begin n_fail++; $display("FAIL starve_order[%0d] got=%0d model=%0d exp=%0d", j, s_gch, s_exp, order[j]); end
        end
        drop_all();
    endtask

    task automatic test_issue_freeze();
        cmd[5:4] = CMD_WR256; addr[AW*2 +: AW] = 23'h2A5A5A;
        cmd[1:0] = CMD_RD256; addr[AW-1:0] = 23'h000123;
        req = 4'b0100;
        serve(3, CMD_NOP, 2, 2, 1'b0, 4'b0001, 1'b0);
        n_checks++; if (s_cmd !== CMD_WR256 || s_addr !== 23'h2A5A5A) begin n_fail++; $display("FAIL freeze_issue got=%b/%h exp=01/2a5a5a", s_cmd, s_addr); end
        n_checks++; if (s_cmd_ack !== CMD_WR256 || s_addr_ack !== 23'h2A5A5A) begin n_fail++; $display("FAIL freeze_hold got=%b/%h exp=01/2a5a5a", s_cmd_ack, s_addr_ack); end
        n_checks++; if (s_gch !== 2 || s_bad !== 0) begin n_fail++; $display("FAIL freeze_gnt got=%0d bad=%0d exp=2/0", s_gch, s_bad); end
        serve(1, CMD_NOP, 2, 1, 1'b1, '0, 1'b0);
        n_checks++; if (s_gch !== 0 || s_cmd !== CMD_RD256 || s_addr !== 23'h000123) begin n_fail++; $display("FAIL freeze_next got=%0d/%b/%h exp=0/11/000123", s_gch, s_cmd, s_addr); end
    endtask

    task automatic test_ack_mismatch();
        cmd[1:0] = CMD_RD256; req = 4'b0001;
        serve(1, CMD_RD32, 2, 0, 1'b1, '0, 1'b0);
        n_checks++; if (s_gch !== 0 || s_to !== 1'b0) begin n_fail++; $display("FAIL mismatch_gnt got=%0d exp=0", s_gch); end
        n_checks++; if (err !== m_err || err !== 1'b1) begin n_fail++; $display("FAIL mismatch_err got=%b exp=1", err); end
        req = 4'b0001;
        serve(1, CMD_NOP, 2, 0, 1'b1, '0, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky got=%b exp=1", err); end
        do_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mismatch_clear got=%b exp=0", err); end
    endtask

    task automatic test_reset_busy();
        int n;
        cmd[3:2] = CMD_RD32; addr[AW +: AW] = 23'h0BEEF; req = 4'b0010;
        n = 0;
        while (sys_CMD === CMD_NOP && n < 20) begin @(negedge clk); n++; end
        ack = CMD_RD32;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt === '0 && n < 10);
        rdv = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 4'b0010) begin n_fail++; $display("FAIL rstbusy_pre got=%b exp=0010", rd_valid); end
        @(negedge clk);
        rst_n = 1'b0; ack = CMD_NOP;
        @(negedge clk);
        #1;
        n_checks++; if (sys_CMD !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rstbusy_state got=%b/%b exp=00/0", sys_CMD, busy); end
        n_checks++; if (rd_valid !== '0) begin n_fail++; $display("FAIL rstbusy_rd_valid got=%b exp=0000", rd_valid); end
        rdv = 1'b0; rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        serve(1, CMD_NOP, 3, 3, 1'b1, '0, 1'b0);
        n_checks++; if (s_gch !== 1 || s_good !== 3 || s_to !== 1'b0) begin n_fail++; $display("FAIL rstbusy_retry got=%0d good=%0d exp=1/3", s_gch, s_good); end
    endtask

    task automatic test_random();
        for (int i = 0; i < NCH; i++) begin
            cmd[2*i +: 2] = 2'($urandom_range(1, 3));
            addr[AW*i +: AW] = AW'($urandom);
        end
        req = 4'($urandom_range(1, 15));
        for (int j = 0; j < 40; j++) begin
            serve($urandom_range(0, 3), CMD_NOP, $urandom_range(1, 4), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), '0, 1'b0);
            n_checks++;
            if (s_to !== 1'b0 || s_gch !== s_exp || s_exp < 0) begin n_fail++; $display("FAIL rand_winner[%0d] got=%0d exp=%0d", j, s_gch, s_exp); end
            else if (s_cmd !== cmd[2*s_exp +: 2] || s_addr !== addr[AW*s_exp +: AW]) begin
                n_fail++; $display("FAIL rand_cmd[%0d] got=%b/%h exp=%b/%h", j, s_cmd, s_addr, cmd[2*s_exp +: 2], addr[AW*s_exp +: AW]);
            end
            n_checks++; if (s_bad !== 0) begin n_fail++; $display("FAIL rand_steering[%0d] bad=%0d exp=0", j, s_bad); end
            for (int i = 0; i < NCH; i++) begin
                if (!req[i]) begin
                    cmd[2*i +: 2] = 2'($urandom_range(1, 3));
                    addr[AW*i +: AW] = AW'($urandom);
                    req[i] = 1'($urandom_range(0, 1));
                end
            end
            if (req == '0) req[$urandom_range(0, NCH - 1)] = 1'b1;
        end
        drop_all();
        @(negedge clk);
        n_checks++; if (err !== m_err || busy !== 1'b0) begin n_fail++; $display("FAIL rand_final got=%b/%b exp=%b/0", err, busy, m_err); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_starvation();
        test_issue_freeze();
        test_ack_mismatch();
        test_reset_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
